// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock tick monitor: FSM encoding and default limits.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_TIMEOUT     = 250000;
  localparam int DEF_LOCK_EDGES  = 2;
  localparam int DEF_TOL         = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by registered
// single-cycle rise/fall pulses. Also used for push-button inputs.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_CLK,
  input  logic rst,
  input  logic I_D,
  output logic O_RISE,
  output logic O_FALL
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // last_q is one extra copy of the final stage; the pulses compare the two.
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      O_RISE <= 1'b0;
      O_FALL <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_D};
      last_q <= sync_out;
      O_RISE <= sync_out & ~last_q;
      O_FALL <= ~sync_out & last_q;
    end
  end

endmodule

// File: rtl/clk_tick_monitor.sv
// Turns a slow asynchronous clock into I_CLK-domain tick enables, measures its
// rise-to-rise period, and tracks lock / loss of that clock.
module clk_tick_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LOCK_EDGES  = DEF_LOCK_EDGES,
  parameter int TOL         = DEF_TOL
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SCLK,
  output logic             O_RISE,
  output logic             O_FALL,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic             O_PERIOD_VLD,
  output logic             O_LOCKED,
  output logic             O_LOST,
  output mon_state_t       O_STATE
);

  localparam int                 MATCH_W = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0]   TMO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   TMO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]     TOL_V   = (CNT_W+1)'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_EDGES);

  logic               rise;
  logic               fall;
  logic [CNT_W-1:0]   cnt_q;
  mon_state_t         state_q, state_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               vld_q, vld_d;
  logic               lost_q, lost_d;
  logic               pvld_q, pvld_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W:0]     p_ext;
  logic [CNT_W:0]     per_ext;
  logic [CNT_W:0]     diff;
  logic               in_tol;
  logic               timeout_hit;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .I_CLK (I_CLK),
    .rst   (rst),
    .I_D   (I_SCLK),
    .O_RISE(rise),
    .O_FALL(fall)
  );

  // Cycles since the last rise tick; parks at TIMEOUT so a dead clock cannot wrap.
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= '0;
    end else if (cnt_q != TMO_V) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Period and difference carry one extra bit so neither can wrap.
  assign p_ext       = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign per_ext     = {1'b0, period_q};
  assign diff        = (p_ext >= per_ext) ? (p_ext - per_ext) : (per_ext - p_ext);
  assign in_tol      = pvld_q && (diff <= TOL_V);
  assign timeout_hit = (cnt_q == TMO_M1) && !rise;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    vld_d    = 1'b0;
    lost_d   = lost_q;
    pvld_d   = pvld_q;
    match_d  = match_q;

    if (rise) begin
      lost_d = 1'b0;
    end

    if (state_q != IDLE && timeout_hit) begin
      state_d = IDLE;
      lost_d  = 1'b1;
      pvld_d  = 1'b0;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = ACQ;
            match_d = '0;
          end
        end
        ACQ: begin
          if (rise) begin
            period_d = p_ext[CNT_W-1:0];
            vld_d    = 1'b1;
            pvld_d   = 1'b1;
            if (in_tol) begin
              if (match_q + MATCH_W'(1) >= LOCK_V) begin
                state_d = LOCKED;
                match_d = LOCK_V;
              end else begin
                match_d = match_q + MATCH_W'(1);
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (rise) begin
            period_d = p_ext[CNT_W-1:0];
            vld_d    = 1'b1;
            pvld_d   = 1'b1;
            if (!in_tol) begin
              state_d = ACQ;
              match_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      vld_q    <= 1'b0;
      lost_q   <= 1'b0;
      pvld_q   <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      lost_q   <= lost_d;
      pvld_q   <= pvld_d;
      match_q  <= match_d;
    end
  end

  assign O_RISE       = rise;
  assign O_FALL       = fall;
  assign O_PERIOD     = period_q;
  assign O_PERIOD_VLD = vld_q;
  assign O_LOCKED     = (state_q == LOCKED);
  assign O_LOST       = lost_q;
  assign O_STATE      = state_q;

endmodule
